// File: rtl/noc_outport_credit.sv
// Output-port transmitter: grant mux, registered link, credit counter, RR turn token.
// Optional sticky protocol checker enabled by NOC_CREDIT_CHECK_EN.
module noc_outport_credit #(
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] N_data_i,
  input  logic [DATA_W-1:0] S_data_i,
  input  logic [DATA_W-1:0] E_data_i,
  input  logic [DATA_W-1:0] W_data_i,
  input  logic [DATA_W-1:0] L_data_i,
  input  logic [4:0]        req_i,
  input  logic [2:0]        port_select,
  input  logic              port_enable,
  input  logic              credit_in,
  output logic              port_full,
  output logic [4:0]        turn,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  credits_nxt;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;
  logic              send;
  logic              advance;

  assign port_full = (credits == '0);
  assign sel_ok    = (port_select <= 3'b100);
  assign send      = port_enable && !port_full && sel_ok;
  assign advance   = send || ((turn & req_i) == 5'b0);

  always_comb begin
    sel_data = '0;
    case (port_select)
      3'd0:    sel_data = N_data_i;
      3'd1:    sel_data = S_data_i;
      3'd2:    sel_data = E_data_i;
      3'd3:    sel_data = W_data_i;
      3'd4:    sel_data = L_data_i;
      default: sel_data = '0;
    endcase
  end

  // Simultaneous send and credit return cancel out.
  always_comb begin
    credits_nxt = credits;
    unique case ({send, credit_in})
      2'b10:   credits_nxt = credits - 1'b1;
      2'b01:   credits_nxt = (credits == CRED_MAX) ? credits
                                                   : credits + 1'b1;
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_MAX;
      turn    <= 5'b10000;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      credits <= credits_nxt;
      valid_o <= send;
      if (send) data_o <= sel_data;
      if (advance) turn <= {turn[0], turn[4:1]};
    end
  end

`ifdef NOC_CREDIT_CHECK_EN
  logic [2:0] holder;
  logic       err_q;
  logic       err_set;

  always_comb begin
    holder = 3'd0;
    unique case (1'b1)
      turn[4]: holder = 3'd0;
      turn[3]: holder = 3'd1;
      turn[2]: holder = 3'd2;
      turn[1]: holder = 3'd3;
      turn[0]: holder = 3'd4;
      default: holder = 3'd0;
    endcase
  end

  assign err_set = (credit_in && !send && credits == CRED_MAX)
                || (port_enable && port_full)
                || (port_enable && !sel_ok)
                || (send && port_select != holder);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_outport_credit.sv
// Bench for noc_outport_credit: directed plan steps plus random traffic
// checked against a credit/turn-index reference model.
module tb_noc_outport_credit;

  localparam int DW  = 8;
  localparam int CR  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din [5];
  logic [4:0]    req_i = '0;
  logic [2:0]    port_select = '0;
  logic          port_enable = 1'b0;
  logic          credit_in = 1'b0;
  logic          port_full;
  logic [4:0]    turn;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  int            m_cred;
  int            m_idx;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_err;

`ifdef NOC_CREDIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  noc_outport_credit #(.DATA_W(DW), .CREDITS(CR), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .N_data_i(din[0]), .S_data_i(din[1]), .E_data_i(din[2]),
    .W_data_i(din[3]), .L_data_i(din[4]),
    .req_i(req_i), .port_select(port_select),
    .port_enable(port_enable), .credit_in(credit_in),
    .port_full(port_full), .turn(turn), .data_o(data_o),
    .valid_o(valid_o), .err_o(err_o)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] turn_of(int i);
    logic [4:0] t;
    t = 5'b10000;
    return t >> i;
  endfunction

  task automatic model_reset();
    m_cred  = CR;
    m_idx   = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
    chk({tag, ".data"}, 32'(data_o), 32'(m_data));
    chk({tag, ".full"}, 32'(port_full), 32'(m_cred == 0));
    chk({tag, ".turn"}, 32'(turn), 32'(turn_of(m_idx)));
    chk({tag, ".err"}, 32'(err_o), 32'(m_err & CHK));
  endtask

  // One clock edge: model consumes the inputs held across the edge.
  task automatic cycle(string tag);
    bit snd;
    int sel;
    @(posedge clk);
    sel = int'(port_select);
    snd = port_enable && m_cred > 0 && sel <= 4;
    if (port_enable && m_cred == 0) m_err = 1'b1;
    if (port_enable && sel > 4) m_err = 1'b1;
    if (credit_in && !snd && m_cred == CR) m_err = 1'b1;
    if (snd && sel != m_idx) m_err = 1'b1;
    m_valid = snd;
    if (snd) m_data = din[sel];
    if (snd && !credit_in) m_cred--;
    else if (credit_in && !snd && m_cred < CR) m_cred++;
    if (snd || !req_i[4-m_idx]) m_idx = (m_idx + 1) % 5;
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges, checked before the next edge.
  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
    port_enable = 1'b0;
    credit_in   = 1'b0;
    req_i       = '0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) din[i] = DW'(8'h10 + i);
    model_reset();
    #12 rst = 1'b0;

    // back-to-back sends from N, then enable while full
    port_select = 3'b000;
    din[0]      = 8'h21;
    port_enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle("b2b");
    chk("b2b.full4", 32'(port_full), 32'd1);
    cycle("b2b_full");
    chk("full.novalid", 32'(valid_o), 32'd0);
    chk("full.err", 32'(err_o), 32'(CHK));

    // credit return, then send plus credit return together
    port_enable = 1'b0;
    credit_in   = 1'b1;
    cycle("cret");
    chk("cret.notfull", 32'(port_full), 32'd0);
    port_enable = 1'b1;
    cycle("cret_send");
    chk("cret_send.cred1", 32'(m_cred), 32'd1);
    port_enable = 1'b0;
    credit_in   = 1'b0;
    cycle("cret_idle");

    // reset mid-transfer then overflow at full credits
    port_enable = 1'b1;
    async_reset("rst1");
    credit_in = 1'b1;
    cycle("ovf");
    chk("ovf.err", 32'(err_o), 32'(CHK));
    credit_in = 1'b0;

    // arbitration: only L requests
    async_reset("rst2");
    req_i = 5'b00001;
    for (int i = 0; i < 6; i++) cycle("arb");
    chk("arb.holdL", 32'(turn), 32'h01);
    din[4]      = 8'hA5;
    port_select = 3'b100;
    port_enable = 1'b1;
    cycle("arb_sendL");
    chk("arb.dataL", 32'(data_o), 32'hA5);
    chk("arb.turnN", 32'(turn), 32'h10);
    chk("arb.noerr", 32'(err_o), 32'd0);
    port_enable = 1'b0;

    // illegal select
    async_reset("rst3");
    port_select = 3'b110;
    port_enable = 1'b1;
    cycle("illegal");
    chk("illegal.novalid", 32'(valid_o), 32'd0);
    chk("illegal.err", 32'(err_o), 32'(CHK));
    port_enable = 1'b0;

    // random traffic
    async_reset("rst4");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) din[i] = DW'($urandom);
      req_i       = 5'($urandom);
      port_enable = ($urandom_range(0, 3) != 0);
      port_select = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                               : 3'($urandom_range(0, 4));
      credit_in   = ($urandom_range(0, 1) == 1);
      if (n % 97 == 96) async_reset("rst_rand");
      else cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
